// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  // Width of every statistics counter.
  localparam int STATS_W = 16;

  // Largest supported requester count; rr_pick works on this fixed width.
  localparam int MAX_REQ = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Round-robin pick: first set bit of req at or after (last+1) mod n.
  // Bits of req at or above n must be zero. Returns 0 when req is empty.
  function automatic logic [2:0] rr_pick(input logic [7:0]  req,
                                         input logic [2:0]  last,
                                         input int unsigned n);
    logic [2:0]  pick;
    logic        found;
    int unsigned idx;
    pick  = 3'd0;
    found = 1'b0;
    for (int unsigned k = 32'd1; k <= 32'd8; k++) begin
      // last < n and k <= n, so one subtraction is enough to wrap.
      idx = 32'(last) + k;
      if (idx >= n) begin
        idx = idx - n;
      end else begin
        idx = idx;
      end
      if ((k <= n) && !found && req[idx[2:0]]) begin
        pick  = idx[2:0];
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin priority picker: request mask plus last-served
// pointer in, chosen index and "any request" flag out.
module rr_priority_pick
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req_i,
  input  logic [$clog2(N_REQ)-1:0] last_i,
  output logic [$clog2(N_REQ)-1:0] pick_o,
  output logic                     any_o
);

  localparam int IDW = $clog2(N_REQ);

  // Rotate priority so the requester after last_i is considered first.
  always_comb begin
    pick_o = IDW'(rr_pick(8'(req_i), 3'(last_i), N_REQ));
    any_o  = |req_i;
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-bounded arbiter sharing the async FIFO write port among
// N_REQ producers in the W_CLK domain. FULL back-pressure stalls the current
// owner without rotating the grant.
// Optional feature macro: FIFO_ARB_STATS_EN adds WR_CNT / STALL_CNT counters.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int data_width = 9,
  parameter int MAX_BURST  = 4
) (
  input  logic                          W_CLK,
  input  logic                          WRST_n,
  input  logic [N_REQ-1:0]              REQ,
  input  logic [N_REQ*data_width-1:0]   DATA,
  output logic [N_REQ-1:0]              ACK,
  output logic [$clog2(N_REQ)-1:0]      GNT_ID,
  input  logic                          FULL,
  output logic                          W_EN,
  output logic [data_width-1:0]         I_DATA
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [N_REQ*STATS_W-1:0]      WR_CNT,
  output logic [STATS_W-1:0]            STALL_CNT
`endif
);

  localparam int IDW   = $clog2(N_REQ);
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
  localparam logic [IDW-1:0]   LAST_INIT = IDW'(N_REQ - 1);

  arb_state_e            state_q, state_d;
  logic [IDW-1:0]        gnt_q, gnt_d;
  logic [IDW-1:0]        last_q, last_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [IDW-1:0]        pick_base_s;
  logic [IDW-1:0]        pick_s;
  logic                  any_req_s;
  logic                  req_own_s;
  logic                  wen_s;
  logic                  grant_end_s;
  logic [N_REQ-1:0]      ack_s;
  logic [data_width-1:0] data_sel_s;

  // In GRANT the owner is the rotation base, otherwise the last served one.
  always_comb begin
    if (state_q == GRANT) begin
      pick_base_s = gnt_q;
    end else begin
      pick_base_s = last_q;
    end
  end

  rr_priority_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req_i  (REQ),
    .last_i (pick_base_s),
    .pick_o (pick_s),
    .any_o  (any_req_s)
  );

  // Write enable: owner requests and the FIFO has room.
  always_comb begin
    req_own_s = REQ[gnt_q];
    wen_s     = (state_q == GRANT) && req_own_s && !FULL;
  end

  // Next-state logic: grant start, burst counting, rotation and release.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    grant_end_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req_s) begin
          state_d = GRANT;
          gnt_d   = pick_s;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        // FULL alone never ends a grant; only a dropped request or a
        // completed burst does.
        if (!req_own_s) begin
          grant_end_s = 1'b1;
        end else if (wen_s && (cnt_q == LAST_BEAT)) begin
          grant_end_s = 1'b1;
        end else if (wen_s) begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          cnt_d = cnt_q;
        end
        if (grant_end_s) begin
          last_d = gnt_q;
          cnt_d  = {CNT_W{1'b0}};
          if (any_req_s) begin
            // Rotate straight to the next requester; may re-grant the owner
            // if it is the only one still asking.
            gnt_d = pick_s;
          end else begin
            state_d = IDLE;
          end
        end else begin
          last_d = last_q;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = {IDW{1'b0}};
        last_d  = LAST_INIT;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge W_CLK or negedge WRST_n) begin
    if (!WRST_n) begin
      state_q <= IDLE;
      gnt_q   <= {IDW{1'b0}};
      last_q  <= LAST_INIT;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // One-hot acknowledge to the producer whose word is written this cycle.
  always_comb begin
    ack_s = {N_REQ{1'b0}};
    if (wen_s) begin
      ack_s[gnt_q] = 1'b1;
    end else begin
      ack_s = {N_REQ{1'b0}};
    end
  end

  // Write data mux; forced to zero when no write happens.
  always_comb begin
    data_sel_s = {data_width{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      data_sel_s = data_sel_s |
                   ({data_width{wen_s && (gnt_q == IDW'(i))}} &
                    DATA[i*data_width +: data_width]);
    end
  end

  assign W_EN   = wen_s;
  assign ACK    = ack_s;
  assign I_DATA = data_sel_s;
  assign GNT_ID = gnt_q;

`ifdef FIFO_ARB_STATS_EN
  localparam logic [STATS_W-1:0] SAT = {STATS_W{1'b1}};

  logic [N_REQ-1:0][STATS_W-1:0] wr_cnt_q;
  logic [STATS_W-1:0]            stall_cnt_q;
  logic                          stall_s;

  // A stall is a granted cycle where the owner wants to write but FULL blocks.
  always_comb begin
    stall_s = (state_q == GRANT) && req_own_s && FULL;
  end

  // Saturating per-requester count of acknowledged words.
  always_ff @(posedge W_CLK or negedge WRST_n) begin
    if (!WRST_n) begin
      for (int i = 0; i < N_REQ; i++) begin
        wr_cnt_q[i] <= {STATS_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (ack_s[i] && (wr_cnt_q[i] != SAT)) begin
          wr_cnt_q[i] <= wr_cnt_q[i] + 16'd1;
        end else begin
          wr_cnt_q[i] <= wr_cnt_q[i];
        end
      end
    end
  end

  // Saturating count of FULL stall cycles.
  always_ff @(posedge W_CLK or negedge WRST_n) begin
    if (!WRST_n) begin
      stall_cnt_q <= {STATS_W{1'b0}};
    end else if (stall_s && (stall_cnt_q != SAT)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_q <= stall_cnt_q;
    end
  end

  assign WR_CNT    = wr_cnt_q;
  assign STALL_CNT = stall_cnt_q;
`else
  // Statistics disabled: no counters and no extra ports.
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter (N_REQ=4, data_width=9,
// MAX_BURST=4): vector table, directed corner sequences, and randomized
// traffic against a behavioural model.
module tb_fifo_write_arbiter;

  localparam int N  = 4;
  localparam int DW = 9;
  localparam int MB = 4;

  logic              W_CLK = 1'b0;
  logic              WRST_n;
  logic [N-1:0]      REQ;
  logic [N*DW-1:0]   DATA;
  logic [N-1:0]      ACK;
  logic [1:0]        GNT_ID;
  logic              FULL;
  logic              W_EN;
  logic [DW-1:0]     I_DATA;
`ifdef FIFO_ARB_STATS_EN
  logic [N*16-1:0]   WR_CNT;
  logic [15:0]       STALL_CNT;
`endif

  fifo_write_arbiter #(
    .N_REQ      (N),
    .data_width (DW),
    .MAX_BURST  (MB)
  ) dut (
    .W_CLK     (W_CLK),
    .WRST_n    (WRST_n),
    .REQ       (REQ),
    .DATA      (DATA),
    .ACK       (ACK),
    .GNT_ID    (GNT_ID),
    .FULL      (FULL),
    .W_EN      (W_EN),
    .I_DATA    (I_DATA)
`ifdef FIFO_ARB_STATS_EN
    ,
    .WR_CNT    (WR_CNT),
    .STALL_CNT (STALL_CNT)
`endif
  );

  always #5 W_CLK = ~W_CLK;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] word [N];

  typedef struct {
    logic [3:0] req;
    logic       full;
    logic       wen;
    logic [3:0] ack;
    logic [1:0] gnt;
  } vec_t;
  vec_t tbl[$];

  // Behavioural model: owner (-1 when nobody holds the port), words written
  // in the current grant, last served producer, displayed grant id.
  int m_owner, m_words, m_last, m_gnt;

  task automatic m_reset();
    m_owner = -1;
    m_words = 0;
    m_last  = N - 1;
    m_gnt   = 0;
  endtask

  function automatic int m_next(input logic [3:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (last + k) % N;
      if (r[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  task automatic m_step(input logic [3:0] r, input logic f);
    bit wrote;
    bit done;
    wrote = (m_owner >= 0) && r[m_owner[1:0]] && !f;
    if (m_owner < 0) begin
      if (r != 4'd0) begin
        m_owner = m_next(r, m_last);
        m_gnt   = m_owner;
        m_words = 0;
      end
    end else begin
      done = !r[m_owner[1:0]];
      if (wrote) begin
        m_words++;
        if (m_words == MB) done = 1'b1;
      end
      if (done) begin
        m_last = m_owner;
        if (r != 4'd0) begin
          m_owner = m_next(r, m_last);
          m_gnt   = m_owner;
          m_words = 0;
        end else begin
          m_owner = -1;
        end
      end
    end
  endtask

  task automatic chk(input string nm, input logic ewen, input logic [3:0] eack,
                     input logic [1:0] egnt, input logic [DW-1:0] edat);
    n_tests++;
    if (W_EN !== ewen || ACK !== eack || GNT_ID !== egnt || I_DATA !== edat) begin
      n_fail++;
      $display("FAIL %s: got W_EN=%b ACK=%b GNT_ID=%0d I_DATA=%h, expected W_EN=%b ACK=%b GNT_ID=%0d I_DATA=%h",
               nm, W_EN, ACK, GNT_ID, I_DATA, ewen, eack, egnt, edat);
    end
  endtask

  // Check with the fixed per-producer words on DATA.
  task automatic chk_h(input string nm, input logic ewen, input logic [3:0] eack,
                       input logic [1:0] egnt);
    chk(nm, ewen, eack, egnt, ewen ? word[egnt] : 9'd0);
  endtask

  task automatic set_in(input logic [3:0] r, input logic f);
    @(negedge W_CLK);
    REQ  = r;
    FULL = f;
    #1;
  endtask

  task automatic set_fixed_data();
    for (int i = 0; i < N; i++) DATA[i*DW +: DW] = word[i];
  endtask

  task automatic apply_reset();
    @(negedge W_CLK);
    REQ  = 4'd0;
    FULL = 1'b0;
    #1;
    WRST_n = 1'b0;
    #1;
    chk("reset", 1'b0, 4'd0, 2'd0, 9'd0);
    repeat (2) @(negedge W_CLK);
    WRST_n = 1'b1;
    m_reset();
  endtask

  task automatic add(input logic [3:0] r, input logic f, input logic w,
                     input logic [3:0] a, input logic [1:0] g);
    vec_t v;
    v.req = r; v.full = f; v.wen = w; v.ack = a; v.gnt = g;
    tbl.push_back(v);
  endtask

  initial begin
    logic [3:0] r;
    logic       f;
    logic       ewen;
    logic [3:0] eack;
    logic [DW-1:0] edat;

    word[0] = 9'h090; word[1] = 9'h1A1; word[2] = 9'h0B2; word[3] = 9'h1C3;
    WRST_n = 1'b0;
    REQ    = 4'd0;
    FULL   = 1'b0;
    DATA   = '0;

    // Vectors: single producer burst, FULL stall, rotation, REQ drop,
    // owner re-grant after a full burst.
    add(4'b0001, 1'b0, 1'b0, 4'b0000, 2'd0);
    add(4'b0001, 1'b0, 1'b1, 4'b0001, 2'd0);
    add(4'b0001, 1'b0, 1'b1, 4'b0001, 2'd0);
    add(4'b0001, 1'b0, 1'b1, 4'b0001, 2'd0);
    add(4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0);
    add(4'b0100, 1'b0, 1'b0, 4'b0000, 2'd0);
    add(4'b0100, 1'b0, 1'b1, 4'b0100, 2'd2);
    add(4'b0100, 1'b1, 1'b0, 4'b0000, 2'd2);
    add(4'b0110, 1'b0, 1'b1, 4'b0100, 2'd2);
    add(4'b0110, 1'b0, 1'b1, 4'b0100, 2'd2);
    add(4'b0110, 1'b0, 1'b1, 4'b0100, 2'd2);
    add(4'b0110, 1'b0, 1'b1, 4'b0010, 2'd1);
    add(4'b0100, 1'b0, 1'b0, 4'b0000, 2'd1);
    add(4'b0100, 1'b0, 1'b1, 4'b0100, 2'd2);
    add(4'b0000, 1'b0, 1'b0, 4'b0000, 2'd2);
    add(4'b1000, 1'b0, 1'b0, 4'b0000, 2'd2);
    add(4'b1000, 1'b0, 1'b1, 4'b1000, 2'd3);
    add(4'b1000, 1'b0, 1'b1, 4'b1000, 2'd3);
    add(4'b1000, 1'b0, 1'b1, 4'b1000, 2'd3);
    add(4'b1000, 1'b0, 1'b1, 4'b1000, 2'd3);
    add(4'b1000, 1'b0, 1'b1, 4'b1000, 2'd3);
    add(4'b0000, 1'b0, 1'b0, 4'b0000, 2'd3);

    set_fixed_data();
    #2;
    WRST_n = 1'b1;
    apply_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      set_in(tbl[i].req, tbl[i].full);
      chk_h($sformatf("tbl%0d", i), tbl[i].wen, tbl[i].ack, tbl[i].gnt);
    end

    // All producers requesting: 0,1,2,3,0 with four back-to-back words each.
    apply_reset();
    set_in(4'b1111, 1'b0);
    chk_h("all_idle", 1'b0, 4'd0, 2'd0);
    for (int k = 0; k < 20; k++) begin
      int g;
      g = (k / MB) % N;
      set_in(4'b1111, 1'b0);
      chk_h($sformatf("all_rr%0d", k), 1'b1, 4'b0001 << g, 2'(g));
    end

    // FULL for 5 cycles after 2 words of producer 2, then 2 more, then rotate.
    apply_reset();
    set_in(4'b0100, 1'b0);
    chk_h("full_idle", 1'b0, 4'd0, 2'd0);
    repeat (2) begin set_in(4'b0100, 1'b0); chk_h("full_pre", 1'b1, 4'b0100, 2'd2); end
    repeat (5) begin set_in(4'b0100, 1'b1); chk_h("full_stall", 1'b0, 4'd0, 2'd2); end
    repeat (2) begin set_in(4'b0101, 1'b0); chk_h("full_post", 1'b1, 4'b0100, 2'd2); end
    set_in(4'b0101, 1'b0);
    chk_h("full_rot", 1'b1, 4'b0001, 2'd0);
    set_in(4'b0000, 1'b0);
    chk_h("full_end", 1'b0, 4'd0, 2'd0);

    // Producer 1 drops after one word while producer 3 waits.
    apply_reset();
    set_in(4'b1010, 1'b0);
    chk_h("drop_idle", 1'b0, 4'd0, 2'd0);
    set_in(4'b1010, 1'b0);
    chk_h("drop_w1", 1'b1, 4'b0010, 2'd1);
    set_in(4'b1000, 1'b0);
    chk_h("drop_gap", 1'b0, 4'd0, 2'd1);
    repeat (4) begin set_in(4'b1010, 1'b0); chk_h("drop_g3", 1'b1, 4'b1000, 2'd3); end
    set_in(4'b1010, 1'b0);
    chk_h("drop_back1", 1'b1, 4'b0010, 2'd1);
    set_in(4'b0000, 1'b0);
    chk_h("drop_end", 1'b0, 4'd0, 2'd1);

    // Asynchronous reset in the middle of a burst (two words written).
    apply_reset();
    set_in(4'b0100, 1'b0);
    repeat (2) begin set_in(4'b0100, 1'b0); chk_h("rst_pre", 1'b1, 4'b0100, 2'd2); end
    @(negedge W_CLK);
    #1;
    WRST_n = 1'b0;
    #1;
    chk_h("rst_mid", 1'b0, 4'd0, 2'd0);
    REQ = 4'b0110;
    @(negedge W_CLK);
    WRST_n = 1'b1;
    #1;
    chk_h("rst_rel", 1'b0, 4'd0, 2'd0);
    set_in(4'b0110, 1'b0);
    chk_h("rst_first", 1'b1, 4'b0010, 2'd1);

`ifdef FIFO_ARB_STATS_EN
    // Ten words from producer 1 with three FULL stall cycles.
    apply_reset();
    set_in(4'b0010, 1'b0);
    repeat (5) set_in(4'b0010, 1'b0);
    repeat (3) set_in(4'b0010, 1'b1);
    repeat (5) set_in(4'b0010, 1'b0);
    set_in(4'b0000, 1'b0);
    n_tests++;
    if (WR_CNT !== {16'd0, 16'd0, 16'd10, 16'd0} || STALL_CNT !== 16'd3) begin
      n_fail++;
      $display("FAIL stats: got WR_CNT=%h STALL_CNT=%0d, expected WR_CNT=%h STALL_CNT=3",
               WR_CNT, STALL_CNT, {16'd0, 16'd0, 16'd10, 16'd0});
    end
`endif

    // Randomized traffic against the behavioural model.
    apply_reset();
    r = 4'd0;
    for (int c = 0; c < 800; c++) begin
      @(negedge W_CLK);
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      f = ($urandom_range(0, 5) == 0);
      REQ  = r;
      FULL = f;
      for (int i = 0; i < N; i++) DATA[i*DW +: DW] = 9'($urandom());
      #1;
      ewen = (m_owner >= 0) && r[m_owner[1:0]] && !f;
      eack = ewen ? (4'b0001 << m_owner) : 4'd0;
      edat = ewen ? DATA[m_owner*DW +: DW] : 9'd0;
      chk($sformatf("rand%0d", c), ewen, eack, 2'(m_gnt), edat);
      m_step(r, f);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
